// File: rtl/ad40xx_pkg.sv
// rtl/ad40xx_pkg.sv - shared types and helpers for the multi-channel AD40xx reader
package ad40xx_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_GAP,
        ST_SHIFT,
        ST_GAIN,
        ST_OUT,
        ST_WAIT
    } ad40xx_state_t;

    // Shortest legal free-run period: conversion, gap, serial read, gain, output, one wait cycle
    function automatic int ad40xx_min_period(input int adc_w, input int sck_div, input int t_conv);
        return t_conv + 1 + 2 * sck_div * adc_w + 3;
    endfunction

endpackage

// File: rtl/ad40xx_gain_sat.sv
// rtl/ad40xx_gain_sat.sv - unsigned fixed-point gain with truncation and saturation for one channel
module ad40xx_gain_sat #(
    parameter int ADC_WIDTH  = 16,
    parameter int GAIN_WIDTH = 16,
    parameter int GAIN_FRAC  = 0
) (
    input  logic [ADC_WIDTH-1:0]  raw,
    input  logic [GAIN_WIDTH-1:0] gain,
    output logic [ADC_WIDTH-1:0]  result,
    output logic                  sat
);

    localparam int PROD_W = ADC_WIDTH + GAIN_WIDTH;

    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] scaled;

    // Full-width product, drop fractional bits, clamp anything above the ADC range to all-ones
    always_comb begin
        prod   = PROD_W'(raw) * PROD_W'(gain);
        scaled = prod >> GAIN_FRAC;
        sat    = |scaled[PROD_W-1:ADC_WIDTH];
        result = sat ? '1 : scaled[ADC_WIDTH-1:0];
    end

endmodule

// File: rtl/ad40xx_multi_read.sv
// rtl/ad40xx_multi_read.sv - shared CNV/SCK reader for NUM_CH parallel AD40xx ADCs with per-channel gain
module ad40xx_multi_read
    import ad40xx_pkg::*;
#(
    parameter int ADC_WIDTH     = 16,
    parameter int NUM_CH        = 4,
    parameter int GAIN_WIDTH    = 16,
    parameter int GAIN_FRAC     = 0,
    parameter int SCK_DIV       = 1,
    parameter int T_CONV        = 16,
    parameter int SAMPLE_PERIOD = 64
) (
    input  logic                         clk,
    input  logic                         sreset,
    input  logic                         enable,
    input  logic                         trig_mode,
    input  logic                         trig,
    input  logic [NUM_CH*GAIN_WIDTH-1:0] gain,
    input  logic [NUM_CH-1:0]            data_in,
    output logic                         cnv,
    output logic                         sck,
    output logic [NUM_CH*ADC_WIDTH-1:0]  raw_data,
    output logic [NUM_CH*ADC_WIDTH-1:0]  amplified_data,
    output logic [NUM_CH-1:0]            sat,
    output logic                         data_valid,
    output logic                         busy,
    output logic                         trig_missed
);

    if (SAMPLE_PERIOD < ad40xx_min_period(ADC_WIDTH, SCK_DIV, T_CONV)) begin : g_period_check
        $error("ad40xx_multi_read: SAMPLE_PERIOD is shorter than one complete frame");
    end

    localparam int CONV_W = $clog2(T_CONV + 1);
    localparam int DIV_W  = $clog2(2 * SCK_DIV + 1);
    localparam int BIT_W  = $clog2(ADC_WIDTH + 1);
    localparam int PER_W  = $clog2(SAMPLE_PERIOD + 1);

    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(T_CONV - 1);
    localparam logic [DIV_W-1:0]  DIV_FALL  = DIV_W'(SCK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HIGH  = DIV_W'(SCK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * SCK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(ADC_WIDTH - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);

    ad40xx_state_t state, state_n;
    logic [CONV_W-1:0] conv_cnt, conv_cnt_n;
    logic [DIV_W-1:0]  div_cnt, div_cnt_n;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [PER_W-1:0]  per_cnt, per_cnt_n;
    logic              start;
    logic              shift_en;
    logic              cnv_n;
    logic              sck_n;

    logic [NUM_CH*GAIN_WIDTH-1:0] gain_shadow;
    logic [NUM_CH*ADC_WIDTH-1:0]  shreg;
    logic [NUM_CH*ADC_WIDTH-1:0]  amp_c;
    logic [NUM_CH-1:0]            sat_c;
    logic [NUM_CH*ADC_WIDTH-1:0]  amp_pipe;
    logic [NUM_CH-1:0]            sat_pipe;

    assign busy     = (state != ST_IDLE);
    assign shift_en = (state == ST_SHIFT) && (div_cnt == DIV_FALL);

    // Next-state and counter logic; cnv/sck are derived from the next state so the pins are registered
    always_comb begin
        state_n    = state;
        conv_cnt_n = conv_cnt;
        div_cnt_n  = div_cnt;
        bit_cnt_n  = bit_cnt;
        per_cnt_n  = (per_cnt == PER_LAST) ? per_cnt : per_cnt + 1'b1;
        start      = 1'b0;

        case (state)
            ST_IDLE: begin
                per_cnt_n = '0;
                if (enable && (!trig_mode || trig)) begin
                    start = 1'b1;
                end
            end
            ST_CONV: begin
                if (conv_cnt == CONV_LAST) begin
                    state_n    = ST_GAP;
                    conv_cnt_n = '0;
                end else begin
                    conv_cnt_n = conv_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                state_n   = ST_SHIFT;
                div_cnt_n = '0;
                bit_cnt_n = '0;
            end
            ST_SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_n = ST_GAIN;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            ST_GAIN: begin
                state_n = ST_OUT;
            end
            ST_OUT: begin
                state_n = trig_mode ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (per_cnt == PER_LAST) begin
                    if (enable && !trig_mode) begin
                        start = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (start) begin
            state_n    = ST_CONV;
            conv_cnt_n = '0;
            per_cnt_n  = '0;
        end

        cnv_n = (state_n == ST_CONV);
        sck_n = (state_n == ST_SHIFT) && (div_cnt_n < DIV_HIGH);
    end

    // One gain/saturate slice per channel, fed from the capture register and the latched gain
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        ad40xx_gain_sat #(
            .ADC_WIDTH (ADC_WIDTH),
            .GAIN_WIDTH(GAIN_WIDTH),
            .GAIN_FRAC (GAIN_FRAC)
        ) u_gain_sat (
            .raw   (shreg[k*ADC_WIDTH +: ADC_WIDTH]),
            .gain  (gain_shadow[k*GAIN_WIDTH +: GAIN_WIDTH]),
            .result(amp_c[k*ADC_WIDTH +: ADC_WIDTH]),
            .sat   (sat_c[k])
        );
    end

    // Sequencer state, pin drivers, capture shift registers, gain pipeline and published outputs
    always_ff @(posedge clk) begin
        if (sreset) begin
            state          <= ST_IDLE;
            conv_cnt       <= '0;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            per_cnt        <= '0;
            cnv            <= 1'b0;
            sck            <= 1'b0;
            gain_shadow    <= '0;
            shreg          <= '0;
            amp_pipe       <= '0;
            sat_pipe       <= '0;
            raw_data       <= '0;
            amplified_data <= '0;
            sat            <= '0;
            data_valid     <= 1'b0;
            trig_missed    <= 1'b0;
        end else begin
            state    <= state_n;
            conv_cnt <= conv_cnt_n;
            div_cnt  <= div_cnt_n;
            bit_cnt  <= bit_cnt_n;
            per_cnt  <= per_cnt_n;
            cnv      <= cnv_n;
            sck      <= sck_n;

            if (start) begin
                gain_shadow <= gain;
            end

            if (shift_en) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    shreg[k*ADC_WIDTH +: ADC_WIDTH] <= {shreg[k*ADC_WIDTH +: ADC_WIDTH-1], data_in[k]};
                end
            end

            if (state == ST_GAIN) begin
                amp_pipe <= amp_c;
                sat_pipe <= sat_c;
            end

            data_valid <= (state == ST_OUT);
            if (state == ST_OUT) begin
                raw_data       <= shreg;
                amplified_data <= amp_pipe;
                sat            <= sat_pipe;
            end

            if (trig && trig_mode && (state != ST_IDLE)) begin
                trig_missed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ad40xx_multi_read.sv
// tb/tb_ad40xx_multi_read.sv - self-checking bench with AD4008-style SDO emulators per channel
module tb_ad40xx_multi_read;

    localparam int WA = 16;
    localparam int NA = 4;
    localparam int WB = 18;
    localparam int NB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic sreset;

    logic             en_a, tm_a, trig_a;
    logic [NA*16-1:0] gain_a;
    logic [NA-1:0]    din_a;
    logic             cnv_a, sck_a, dv_a, busy_a, miss_a;
    logic [NA*WA-1:0] raw_a, amp_a;
    logic [NA-1:0]    sat_a;

    logic             en_b, tm_b, trig_b;
    logic [NB*16-1:0] gain_b;
    logic [NB-1:0]    din_b;
    logic             cnv_b, sck_b, dv_b, busy_b, miss_b;
    logic [NB*WB-1:0] raw_b, amp_b;
    logic [NB-1:0]    sat_b;

    ad40xx_multi_read dut_a (
        .clk(clk), .sreset(sreset), .enable(en_a), .trig_mode(tm_a), .trig(trig_a),
        .gain(gain_a), .data_in(din_a), .cnv(cnv_a), .sck(sck_a), .raw_data(raw_a),
        .amplified_data(amp_a), .sat(sat_a), .data_valid(dv_a), .busy(busy_a), .trig_missed(miss_a)
    );

    ad40xx_multi_read #(
        .ADC_WIDTH(WB), .NUM_CH(NB), .GAIN_WIDTH(16), .GAIN_FRAC(8),
        .SCK_DIV(2), .T_CONV(16), .SAMPLE_PERIOD(96)
    ) dut_b (
        .clk(clk), .sreset(sreset), .enable(en_b), .trig_mode(tm_b), .trig(trig_b),
        .gain(gain_b), .data_in(din_b), .cnv(cnv_b), .sck(sck_b), .raw_data(raw_b),
        .amplified_data(amp_b), .sat(sat_b), .data_valid(dv_b), .busy(busy_b), .trig_missed(miss_b)
    );

    // ADC emulators: word loaded on CNV fall (MSB on SDO), next bit presented after each SCK fall
    logic [NA*WA-1:0] words_a = '0, sr_a = '0;
    logic [NB*WB-1:0] words_b = '0, sr_b = '0;
    logic cnv_a_q = 1'b0, sck_a_q = 1'b0, cnv_b_q = 1'b0, sck_b_q = 1'b0;

    always @(posedge clk) begin
        #1;
        if (cnv_a_q && !cnv_a) sr_a = words_a;
        else if (sck_a_q && !sck_a)
            for (int k = 0; k < NA; k++) sr_a[k*WA +: WA] = {sr_a[k*WA +: WA-1], 1'b0};
        for (int k = 0; k < NA; k++) din_a[k] = sr_a[k*WA + WA - 1];
        cnv_a_q = cnv_a;
        sck_a_q = sck_a;
        if (cnv_b_q && !cnv_b) sr_b = words_b;
        else if (sck_b_q && !sck_b)
            for (int k = 0; k < NB; k++) sr_b[k*WB +: WB] = {sr_b[k*WB +: WB-1], 1'b0};
        for (int k = 0; k < NB; k++) din_b[k] = sr_b[k*WB + WB - 1];
        cnv_b_q = cnv_b;
        sck_b_q = sck_b;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference model: per channel min(floor(raw*gain / 2^frac), 2^w-1)
    function automatic logic [63:0] model_amp(input logic [63:0] raw, input logic [63:0] g_all,
                                              input int n, input int w, input int gw, input int frac);
        logic [63:0] res, x, g, p, mx;
        res = '0;
        mx = (64'd1 << w) - 64'd1;
        for (int k = 0; k < n; k++) begin
            x = (raw >> (k * w)) & mx;
            g = (g_all >> (k * gw)) & ((64'd1 << gw) - 64'd1);
            p = (x * g) >> frac;
            if (p > mx) p = mx;
            res = res | (p << (k * w));
        end
        return res;
    endfunction

    function automatic logic [63:0] model_sat(input logic [63:0] raw, input logic [63:0] g_all,
                                              input int n, input int w, input int gw, input int frac);
        logic [63:0] res, x, g, mx;
        res = '0;
        mx = (64'd1 << w) - 64'd1;
        for (int k = 0; k < n; k++) begin
            x = (raw >> (k * w)) & mx;
            g = (g_all >> (k * gw)) & ((64'd1 << gw) - 64'd1);
            if (((x * g) >> frac) > mx) res[k] = 1'b1;
        end
        return res;
    endfunction

    task automatic wait_dv_a(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!dv_a && n < 500);
        check("dv_a_arrives", dv_a, 1);
    endtask

    task automatic wait_dv_b(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!dv_b && n < 500);
        check("dv_b_arrives", dv_b, 1);
    endtask

    task automatic wait_cnv_a();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!cnv_a && n < 200);
        check("cnv_a_rises", cnv_a, 1);
    endtask

    task automatic fire_a();
        @(negedge clk) trig_a = 1'b1;
        @(negedge clk) trig_a = 1'b0;
        check("cnv_a_after_trig", cnv_a, 1);
    endtask

    task automatic fire_b();
        @(negedge clk) trig_b = 1'b1;
        @(negedge clk) trig_b = 1'b0;
        check("cnv_b_after_trig", cnv_b, 1);
    endtask

    logic [63:0] exp_raw, exp_amp, exp_sat;

    task automatic set_random_a();
        for (int k = 0; k < NA; k++) begin
            words_a[k*16 +: 16] = 16'($urandom);
            gain_a[k*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 3));
        end
        exp_raw = words_a;
        exp_amp = model_amp(words_a, gain_a, NA, WA, 16, 0);
        exp_sat = model_sat(words_a, gain_a, NA, WA, 16, 0);
    endtask

    typedef struct packed {
        logic [63:0] raw;
        logic [63:0] gain;
        logic [63:0] amp;
        logic [3:0]  sat;
    } vec_a_t;

    typedef struct packed {
        logic [35:0] raw;
        logic [31:0] gain;
        logic [35:0] amp;
        logic [1:0]  sat;
    } vec_b_t;

    vec_a_t va[5];
    vec_b_t vb[3];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, cnt, pulses, guard;
        logic prev;

        va[0] = '{64'h1234_5678_00F0_AAAA, 64'h0001_0001_0001_0001, 64'h1234_5678_00F0_AAAA, 4'b0000};
        va[1] = '{64'h1234_5678_00F0_AAAA, 64'h0002_0002_0002_0002, 64'h2468_ACF0_01E0_FFFF, 4'b0001};
        va[2] = '{64'hFFFF_0001_8000_7FFF, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 4'b0000};
        va[3] = '{64'hFFFF_8000_5555_7FFF, 64'hFFFF_0002_0003_0002, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1100};
        va[4] = '{64'h0002_0001_0000_0100, 64'h8000_FFFF_FFFF_0004, 64'hFFFF_FFFF_0000_0400, 4'b1000};

        vb[0] = '{{18'h2AAAA, 18'h01000}, {16'h0100, 16'h0180}, {18'h2AAAA, 18'h01800}, 2'b00};
        vb[1] = '{{18'h3FFFF, 18'h00003}, {16'h0200, 16'h0055}, {18'h3FFFF, 18'h00000}, 2'b10};
        vb[2] = '{{18'h20000, 18'h3FFFF}, {16'h0100, 16'h00FF}, {18'h20000, 18'h3FBFF}, 2'b00};

        sreset = 1'b1;
        en_a = 1'b0; tm_a = 1'b1; trig_a = 1'b0; gain_a = '0;
        en_b = 1'b0; tm_b = 1'b1; trig_b = 1'b0; gain_b = '0;
        repeat (3) @(negedge clk);

        check("rst_cnv", cnv_a, 0);
        check("rst_sck", sck_a, 0);
        check("rst_raw", raw_a, 0);
        check("rst_amp", amp_a, 0);
        check("rst_sat", sat_a, 0);
        check("rst_dv", dv_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_miss", miss_a, 0);
        check("rst_b_raw", raw_b, 0);
        check("rst_b_busy", busy_b, 0);

        sreset = 1'b0; en_a = 1'b1; en_b = 1'b1;
        repeat (3) @(negedge clk);
        check("trigmode_idle_no_trig", busy_a, 0);

        // Table-driven vectors, trigger mode
        for (int i = 0; i < 5; i++) begin
            words_a = va[i].raw;
            gain_a = va[i].gain;
            fire_a();
            wait_dv_a(lat);
            check($sformatf("vec%0d_latency", i), lat, 51);
            check($sformatf("vec%0d_raw", i), raw_a, va[i].raw);
            check($sformatf("vec%0d_amp", i), amp_a, va[i].amp);
            check($sformatf("vec%0d_sat", i), sat_a, va[i].sat);
            check($sformatf("vec%0d_model", i), amp_a, model_amp(va[i].raw, va[i].gain, NA, WA, 16, 0));
            @(negedge clk);
            check($sformatf("vec%0d_dv_one_cycle", i), dv_a, 0);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_idle_after", i), busy_a, 0);
        end
        check("miss_clear_before", miss_a, 0);

        // Second trigger during SHIFT is dropped and sticky-flagged
        fire_a();
        repeat (25) @(negedge clk);
        check("in_shift_busy", busy_a, 1);
        trig_a = 1'b1;
        @(negedge clk) trig_a = 1'b0;
        check("trig_missed_set", miss_a, 1);
        wait_dv_a(lat);
        cnt = 0;
        repeat (80) begin @(negedge clk); if (cnv_a) cnt++; end
        check("dropped_trig_no_frame", cnt, 0);
        check("trig_missed_sticky", miss_a, 1);

        // Free-run with randomized words and gains against the model
        set_random_a();
        tm_a = 1'b0;
        for (int f = 0; f < 8; f++) begin
            wait_dv_a(lat);
            if (f > 0) check($sformatf("fr%0d_period", f), lat, 64);
            check($sformatf("fr%0d_raw", f), raw_a, exp_raw);
            check($sformatf("fr%0d_amp", f), amp_a, exp_amp);
            check($sformatf("fr%0d_sat", f), sat_a, exp_sat);
            set_random_a();
        end

        // Gain change during CONV applies to the following frame only
        words_a[15:0] = 16'h0100;
        gain_a[15:0] = 16'h0001;
        wait_cnv_a();
        repeat (4) @(negedge clk);
        gain_a[15:0] = 16'h0004;
        wait_dv_a(lat);
        check("gainchg_cur_frame", amp_a[15:0], 16'h0100);
        wait_dv_a(lat);
        check("gainchg_next_period", lat, 64);
        check("gainchg_next_frame", amp_a[15:0], 16'h0400);

        // Enable dropped mid-frame: frame completes, no restart
        wait_cnv_a();
        en_a = 1'b0;
        wait_dv_a(lat);
        cnt = 0;
        repeat (150) begin @(negedge clk); if (cnv_a) cnt++; end
        check("disable_no_restart", cnt, 0);
        check("disable_idle", busy_a, 0);

        // Reset after five SCK pulses discards the frame
        set_random_a();
        en_a = 1'b1;
        wait_cnv_a();
        pulses = 0; prev = 1'b0; guard = 0;
        while (pulses < 5 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (prev && !sck_a) pulses++;
            prev = sck_a;
        end
        check("rst_shift_pulses", pulses, 5);
        sreset = 1'b1;
        @(negedge clk);
        check("rshift_cnv", cnv_a, 0);
        check("rshift_sck", sck_a, 0);
        check("rshift_busy", busy_a, 0);
        check("rshift_raw", raw_a, 0);
        check("rshift_amp", amp_a, 0);
        check("rshift_sat", sat_a, 0);
        check("rshift_miss", miss_a, 0);
        cnt = 0;
        if (dv_a) cnt++;
        repeat (2) begin @(negedge clk); if (dv_a) cnt++; end
        check("rshift_no_dv", cnt, 0);
        set_random_a();
        sreset = 1'b0;
        @(negedge clk);
        check("rshift_cnv_after_release", cnv_a, 1);
        wait_dv_a(lat);
        check("rshift_latency", lat, 51);
        check("rshift_next_raw", raw_a, exp_raw);
        check("rshift_next_amp", amp_a, exp_amp);
        check("rshift_next_sat", sat_a, exp_sat);
        en_a = 1'b0;

        // 18-bit, SCK_DIV=2, fractional gain instance
        for (int i = 0; i < 3; i++) begin
            words_b = vb[i].raw;
            gain_b = vb[i].gain;
            fire_b();
            wait_dv_b(lat);
            check($sformatf("b%0d_latency", i), lat, 91);
            check($sformatf("b%0d_raw", i), raw_b, vb[i].raw);
            check($sformatf("b%0d_amp", i), amp_b, vb[i].amp);
            check($sformatf("b%0d_sat", i), sat_b, vb[i].sat);
            check($sformatf("b%0d_model", i), amp_b, model_amp(vb[i].raw, vb[i].gain, NB, WB, 16, 8));
            repeat (3) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
